instr_fetch_unit: RTL

- Consumer end of the program-counter interface. Accepts a fetch address from the PC logic, issues a single-outstanding read to instruction memory over a valid/ready request channel, and returns the fetched word to decode over a valid/ready channel.
- Handles flush on taken jump/branch by discarding stale responses.
- Converts a hung memory access into an error-tagged NOP via a timeout counter.

---
 rtl/instr_fetch_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Consumer end of the program-counter interface. Takes one fetch address at a
//   time, issues a single-outstanding read to instruction memory over a
//   valid/ready request channel, and hands the fetched word to decode over a
//   valid/ready channel. A flush (taken jump/branch) discards whatever is in
//   flight or held. A memory access that never answers is abandoned after
//   TIMEOUT_CYCLES and replaced by an error-tagged NOP.
//
// Optional feature (compile-time macro FETCH_MISALIGN_CHECK_EN):
//   When defined, a fetch whose address is not word aligned never reaches
//   memory; it is answered directly with an error-tagged NOP.
//
// Ports:
//   clk, resetN                  clock, asynchronous active-low reset
//   fetchReq/fetchAddr/fetchReady   fetch request from PC logic
//   flush                        discard in-flight or held instruction
//   memReqValid/memReqAddr/memReqReady   memory read request channel
//   memRespValid/memRespData     memory read response
//   instrValid/instr/instrPc/instrErr/instrReady   instruction to decode
//
// All outputs are driven from state and registers only.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] NOP_WORD       = 'h00000013
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              fetchReq,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic              fetchReady,
  input  logic              flush,
  output logic              memReqValid,
  output logic [ADDR_W-1:0] memReqAddr,
  input  logic              memReqReady,
  input  logic              memRespValid,
  input  logic [DATA_W-1:0] memRespData,
  output logic              instrValid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instrPc,
  output logic              instrErr,
  input  logic              instrReady
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flush_pend_q, flush_pend_d;

  logic                timeout;
  logic [CNT_W-1:0]    cnt_inc;

  // The counter parks at CNT_MAX instead of wrapping.
  assign timeout = (cnt_q == CNT_MAX);
  assign cnt_inc = timeout ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;

    case (state_q)
      IDLE: begin
        // flush has no effect here; a simultaneous fetch is still taken.
        flush_pend_d = 1'b0;
        if (fetchReq) begin
          addr_d = fetchAddr;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (fetchAddr[1:0] != 2'b00) begin
            instr_d = NOP_WORD;
            err_d   = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end

      REQ: begin
        // The request cannot be withdrawn once raised, so a flush seen while
        // waiting for memReqReady is remembered and applied on acceptance.
        if (memReqReady) begin
          cnt_d        = '0;
          flush_pend_d = 1'b0;
          state_d      = (flush || flush_pend_q) ? DRAIN : WAIT;
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end

      WAIT: begin
        cnt_d = cnt_inc;
        if (memRespValid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            instr_d = memRespData;
            err_d   = 1'b0;
            state_d = HOLD;
          end
        end else if (flush) begin
          // Response still owed by memory; swallow it in DRAIN.
          state_d = DRAIN;
        end else if (timeout) begin
          instr_d = NOP_WORD;
          err_d   = 1'b1;
          state_d = HOLD;
        end
      end

      DRAIN: begin
        cnt_d = cnt_inc;
        if (memRespValid || timeout) begin
          state_d = IDLE;
        end
      end

      HOLD: begin
        if (flush || instrReady) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      instr_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign fetchReady  = (state_q == IDLE);
  assign memReqValid = (state_q == REQ);
  assign memReqAddr  = addr_q;
  assign instrValid  = (state_q == HOLD);
  assign instr       = instr_q;
  assign instrPc     = addr_q;
  assign instrErr    = err_q;

endmodule
